// File: rtl/fp_mult_arbiter_if.sv
// Handshake bundle between the requesters, the shared FP32 multiplier and fp_mult_arbiter.
// The arbiter connects through the slave modport; the requester/multiplier side uses master.
interface fp_mult_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_last;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic                mult_valid_in;
  logic [31:0]         mult_a;
  logic [31:0]         mult_b;
  logic                mult_valid_out;
  logic [31:0]         mult_out;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_data;
  logic                tag_err;

  modport slave (
    input  req_valid, req_last, req_a, req_b, mult_valid_out, mult_out,
    output req_ready, mult_valid_in, mult_a, mult_b, rsp_valid, rsp_data, tag_err
  );

  modport master (
    output req_valid, req_last, req_a, req_b, mult_valid_out, mult_out,
    input  req_ready, mult_valid_in, mult_a, mult_b, rsp_valid, rsp_data, tag_err
  );
endinterface

// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter with burst lock sharing one FP32 multiplier; a tag pipeline steers products back.
// Optional per-requester accepted-beat counters are built when FP_ARB_PERF_CNT_EN is defined.
module fp_mult_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MULT_LAT = 1
) (
  input  logic                clk,
  input  logic                resetn,
  fp_mult_arbiter_if.slave    bus
`ifdef FP_ARB_PERF_CNT_EN
  ,
  input  logic                perf_clr,
  output logic [32*N_REQ-1:0] perf_cnt
`endif
);

  // state | meaning
  // IDLE  | round-robin search from ptr, single beats move ptr past the winner
  // LOCK  | only owner may issue until its req_last beat; bubbles issue nothing

  localparam int IW = $clog2(N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    cand;
  logic             gnt_found;
  logic             gnt_last;
  logic             accept;
  logic [N_REQ-1:0] ready;
  logic [IW-1:0]    issue_idx_q;

  logic [MULT_LAT-1:0] tag_v_q;
  logic [IW-1:0]       tag_idx_q [MULT_LAT];
  logic                tag_v_last;
  logic [IW-1:0]       tag_idx_last;
  logic [N_REQ-1:0]    rsp;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (int'(v) == N_REQ - 1) return '0;
    return v + IW'(1);
  endfunction

  // Grant search: the owner alone while locked, otherwise first valid from ptr upward.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (state_q == LOCK) begin
      gnt_found = bus.req_valid[owner_q];
      gnt_idx   = owner_q;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = IW'((int'(ptr_q) + k) % N_REQ);
        if (!gnt_found && bus.req_valid[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    if (gnt_found && resetn) ready[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign accept        = |ready;
  assign gnt_last      = bus.req_last[gnt_idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (gnt_last) begin
            ptr_d = wrap_inc(gnt_idx);
          end else begin
            owner_d = gnt_idx;
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        if (accept && gnt_last) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue register; operands hold between issues so the multiplier inputs stay quiet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.mult_valid_in <= 1'b0;
      bus.mult_a        <= '0;
      bus.mult_b        <= '0;
      issue_idx_q       <= '0;
    end else begin
      bus.mult_valid_in <= accept;
      if (accept) begin
        bus.mult_a  <= bus.req_a[32*gnt_idx +: 32];
        bus.mult_b  <= bus.req_b[32*gnt_idx +: 32];
        issue_idx_q <= gnt_idx;
      end
    end
  end

  // Tag stage 0 follows the issue register, so the last stage lines up with mult_valid_out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_v_q <= '0;
      for (int s = 0; s < MULT_LAT; s++) tag_idx_q[s] <= '0;
    end else begin
      tag_v_q[0]   <= bus.mult_valid_in;
      tag_idx_q[0] <= issue_idx_q;
      for (int s = 1; s < MULT_LAT; s++) begin
        tag_v_q[s]   <= tag_v_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
    end
  end

  assign tag_v_last   = tag_v_q[MULT_LAT-1];
  assign tag_idx_last = tag_idx_q[MULT_LAT-1];

  always_comb begin
    rsp = '0;
    if (bus.mult_valid_out && tag_v_last) rsp[tag_idx_last] = 1'b1;
  end

  assign bus.rsp_valid = rsp;
  assign bus.rsp_data  = bus.mult_out;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.tag_err <= 1'b0;
    end else if (bus.mult_valid_out != tag_v_last) begin
      bus.tag_err <= 1'b1;
    end
  end

`ifdef FP_ARB_PERF_CNT_EN
  logic [31:0] cnt_q [N_REQ];

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (perf_clr) begin
          cnt_q[i] <= '0;
        end else if (ready[i] && (cnt_q[i] != 32'hFFFF_FFFF)) begin
          cnt_q[i] <= cnt_q[i] + 32'd1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf
    assign perf_cnt[32*gi +: 32] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter: a behavioural arbiter/response model checked every cycle,
// plus hand-computed grant orders, latencies and error-flag expectations.
`timescale 1ns/1ps
module tb_fp_mult_arbiter;
  localparam int N_REQ    = 4;
  localparam int MULT_LAT = 1;
  localparam int LAT      = 1 + MULT_LAT;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic inject = 1'b0;
  always #5 clk = ~clk;

  fp_mult_arbiter_if #(.N_REQ(N_REQ)) bus ();

`ifdef FP_ARB_PERF_CNT_EN
  logic                perf_clr = 1'b0;
  logic [32*N_REQ-1:0] perf_cnt;
`endif

  fp_mult_arbiter #(.N_REQ(N_REQ), .MULT_LAT(MULT_LAT)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus)
`ifdef FP_ARB_PERF_CNT_EN
    ,
    .perf_clr(perf_clr),
    .perf_cnt(perf_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Normal-number FP32 multiply with truncation; stimulus uses exactly representable products.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int          e;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      return {a[31] ^ b[31], e[7:0], p[46:24]};
    end
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  // Multiplier stand-in with MULT_LAT register stages; inject fakes a result with no issue.
  logic [MULT_LAT-1:0] mv_pipe;
  logic [31:0]         mo_pipe [MULT_LAT];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mv_pipe <= '0;
      for (int s = 0; s < MULT_LAT; s++) mo_pipe[s] <= '0;
    end else begin
      mv_pipe[0] <= bus.mult_valid_in | inject;
      mo_pipe[0] <= fp_mul(bus.mult_a, bus.mult_b);
      for (int s = 1; s < MULT_LAT; s++) begin
        mv_pipe[s] <= mv_pipe[s-1];
        mo_pipe[s] <= mo_pipe[s-1];
      end
    end
  end
  assign bus.mult_valid_out = mv_pipe[MULT_LAT-1];
  assign bus.mult_out       = mo_pipe[MULT_LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rq[$];
  int          gnt_log[$];
  int          gnt_cyc_log[$];
  int          rsp_idx_log[$];
  int          rsp_cyc_log[$];
  bit          m_lock;
  int          m_ptr, m_owner;
  bit          m_issue;
  bit          m_err;
  int          inject_due = -1;

  // Behavioural model and per-cycle compare, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_ready, exp_rsp;
    logic [31:0]      exp_data;
    int               g;
    rsp_t             e;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_ready[i]) begin
        gnt_log.push_back(i);
        gnt_cyc_log.push_back(cyc);
      end
      if (bus.rsp_valid[i]) begin
        rsp_idx_log.push_back(i);
        rsp_cyc_log.push_back(cyc);
      end
    end
    if (!resetn) begin
      m_lock = 0; m_ptr = 0; m_owner = 0; m_issue = 0; m_err = 0;
      inject_due = -1;
      rq.delete();
      check("ready_in_reset", 64'(bus.req_ready), 64'd0);
      check("rsp_in_reset", 64'(bus.rsp_valid), 64'd0);
      check("err_in_reset", 64'(bus.tag_err), 64'd0);
    end else begin
      g = -1;
      if (m_lock) begin
        if (bus.req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < N_REQ; k++)
          if (g < 0 && bus.req_valid[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_rsp  = '0;
      exp_data = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        exp_rsp[rq[0].idx] = 1'b1;
        exp_data = rq[0].data;
        void'(rq.pop_front());
      end
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check("mult_valid_in", 64'(bus.mult_valid_in), 64'(m_issue));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
      if (exp_rsp != '0) check("rsp_data", 64'(bus.rsp_data), 64'(exp_data));
      check("tag_err", 64'(bus.tag_err), 64'(m_err));
      m_issue = (g >= 0);
      if (g >= 0) begin
        e.due  = cyc + LAT;
        e.idx  = g;
        e.data = fp_mul(bus.req_a[32*g +: 32], bus.req_b[32*g +: 32]);
        rq.push_back(e);
        if (m_lock) begin
          if (bus.req_last[g]) begin
            m_lock = 0;
            m_ptr  = (m_owner + 1) % N_REQ;
          end
        end else if (bus.req_last[g]) begin
          m_ptr = (g + 1) % N_REQ;
        end else begin
          m_lock  = 1;
          m_owner = g;
        end
      end
      if (inject_due == cyc) m_err = 1;
      if (inject) inject_due = cyc + 1;
    end
  end

  task automatic drive(input logic [N_REQ-1:0] v, input logic [N_REQ-1:0] l, input int beat);
    bus.req_valid = v;
    bus.req_last  = l;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_a[32*i +: 32] = 32'h3F80_0000 | 32'(i << 19) | 32'(beat << 15);
      bus.req_b[32*i +: 32] = 32'h4000_0000 | 32'(beat << 18);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic log_gnt(input string name, input int base, input int pos, input int exp);
    check(name, (base + pos < gnt_log.size()) ? 64'(gnt_log[base + pos]) : 64'hFFFF, 64'(exp));
  endtask

  initial begin
    int gl0, rl0;
    int exp_burst[5] = '{1, 1, 1, 2, 0};
    int exp_rr[6]    = '{0, 1, 2, 3, 0, 1};

    drive('0, '0, 0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Single beat from requester 0: 1.0 * 2.0
    drive(4'b0001, 4'b0001, 0);
    @(negedge clk);
    check("single_ready", 64'(bus.req_ready), 64'h1);
    step();
    drive('0, '0, 0);
    @(negedge clk);
    check("single_issue", 64'(bus.mult_valid_in), 64'h1);
    check("single_mult_a", 64'(bus.mult_a), 64'h3F80_0000);
    @(negedge clk);
    check("single_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("single_rsp_data", 64'(bus.rsp_data), 64'h4000_0000);

    // Burst from requester 1 (ptr=1) with 0 and 2 also valid, bubble after beat 2
    gl0 = gnt_log.size();
    step(); drive(4'b0111, 4'b0101, 1);
    step(); drive(4'b0111, 4'b0101, 2);
    step(); drive(4'b0101, 4'b0101, 3);
    @(negedge clk);
    check("bubble_ready", 64'(bus.req_ready), 64'h0);
    step(); drive(4'b0111, 4'b0111, 3);
    step(); drive(4'b0101, 4'b0101, 4);
    step(); drive(4'b0101, 4'b0101, 5);
    step(); drive('0, '0, 0);
    repeat (3) step();
    for (int i = 0; i < 5; i++) log_gnt($sformatf("burst_gnt%0d", i), gl0, i, exp_burst[i]);

    // Reset while locked with one beat in flight
    step(); drive(4'b0010, 4'b0000, 6);
    step(); drive(4'b1110, 4'b0000, 7); resetn = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'h0);
    step(); resetn = 1'b1; drive(4'b1100, 4'b1100, 8);
    @(negedge clk);
    check("post_rst_no_rsp", 64'(bus.rsp_valid), 64'h0);
    check("post_rst_gnt", 64'(bus.req_ready), 64'h4);
    check("post_rst_err", 64'(bus.tag_err), 64'h0);
    step(); drive('0, '0, 0);
    repeat (3) step();

    // Fresh reset so round-robin starts at ptr=0
    resetn = 1'b0;
    step(); resetn = 1'b1;
    gl0 = gnt_log.size();
    rl0 = rsp_idx_log.size();
    for (int b = 0; b < 6; b++) begin
      drive(4'b1111, 4'b1111, b + 1);
      step();
    end
    drive('0, '0, 0);
    repeat (4) step();
    for (int i = 0; i < 6; i++) log_gnt($sformatf("rr_gnt%0d", i), gl0, i, exp_rr[i]);
    check("rr_rsp_count", 64'(rsp_idx_log.size() - rl0), 64'd6);
    if (rsp_idx_log.size() - rl0 >= 6 && gnt_cyc_log.size() - gl0 >= 1) begin
      check("rr_latency", 64'(rsp_cyc_log[rl0] - gnt_cyc_log[gl0]), 64'd2);
      for (int i = 0; i < 6; i++) begin
        check($sformatf("rr_rsp_idx%0d", i), 64'(rsp_idx_log[rl0 + i]), 64'(exp_rr[i]));
        check($sformatf("rr_rsp_cyc%0d", i), 64'(rsp_cyc_log[rl0 + i] - rsp_cyc_log[rl0]), 64'(i));
      end
    end

    // Spurious multiplier result with nothing in flight
    inject = 1'b1;
    step(); inject = 1'b0;
    @(negedge clk);
    check("err_rsp_zero", 64'(bus.rsp_valid), 64'h0);
    @(negedge clk);
    check("err_set", 64'(bus.tag_err), 64'h1);
    step(); drive(4'b1000, 4'b1000, 9);
    step(); drive('0, '0, 0);
    repeat (3) step();
    check("err_sticky", 64'(bus.tag_err), 64'h1);
    resetn = 1'b0;
    step(); resetn = 1'b1;
    @(negedge clk);
    check("err_cleared", 64'(bus.tag_err), 64'h0);

`ifdef FP_ARB_PERF_CNT_EN
    step(); perf_clr = 1'b1;
    step(); perf_clr = 1'b0;
    for (int b = 0; b < 5; b++) begin
      drive(4'b0100, 4'b0100, b);
      step();
    end
    drive('0, '0, 0);
    @(negedge clk);
    check("perf_cnt2", 64'(perf_cnt[95:64]), 64'd5);
    check("perf_cnt0", 64'(perf_cnt[31:0]), 64'd0);
    step(); perf_clr = 1'b1;
    step(); perf_clr = 1'b0;
    @(negedge clk);
    check("perf_cnt2_clr", 64'(perf_cnt[95:64]), 64'd0);
`endif

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
